// File: rtl/mem_responder.sv
// Byte-addressed big-endian word memory for the CPU bus plus a loader write port; reads return after RD_LATENCY edges.
// There is no backpressure: every edge samples a read, and loader writes take priority over CPU writes.
module mem_responder #(
  parameter int ADDR_BITS  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic                 Wr,
  input  logic [31:0]          Datain,
  output logic [31:0]          Dataout,
  output logic                 rd_valid,
  output logic                 addr_err,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [31:0]          ld_data,
  output logic                 ld_clash
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef logic [ADDR_BITS-1:0] idx_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        valid;
  } rd_stage_t;

  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
    $error("mem_responder: RD_LATENCY must be in 1..3");
  end

  logic [7:0] mem [DEPTH];

  // Byte lanes wrap modulo the array size; misaligned words are allowed.
  idx_t rd_idx0, rd_idx1, rd_idx2, rd_idx3;
  idx_t wr_idx0, wr_idx1, wr_idx2, wr_idx3;
  idx_t wr_base;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic        wr_en;
  logic        rd_err;

  always_comb begin
    rd_idx0 = Address[ADDR_BITS-1:0];
    rd_idx1 = rd_idx0 + idx_t'(1);
    rd_idx2 = rd_idx0 + idx_t'(2);
    rd_idx3 = rd_idx0 + idx_t'(3);
    rd_word = {mem[rd_idx0], mem[rd_idx1], mem[rd_idx2], mem[rd_idx3]};
    rd_err  = (Address[31:ADDR_BITS] != '0);
  end

  always_comb begin
    wr_en   = ld_en | Wr;
    wr_base = ld_en ? ld_addr : Address[ADDR_BITS-1:0];
    wr_word = ld_en ? ld_data : Datain;
    wr_idx0 = wr_base;
    wr_idx1 = wr_base + idx_t'(1);
    wr_idx2 = wr_base + idx_t'(2);
    wr_idx3 = wr_base + idx_t'(3);
  end

  // Storage is never cleared; reset only suppresses writes while asserted.
  always_ff @(posedge clock) begin
    if (reset && wr_en) begin
      mem[wr_idx0] <= wr_word[31:24];
      mem[wr_idx1] <= wr_word[23:16];
      mem[wr_idx2] <= wr_word[15:8];
      mem[wr_idx3] <= wr_word[7:0];
    end
  end

  rd_stage_t pipe [RD_LATENCY];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= {rd_word, rd_err, 1'b1};
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_clash <= 1'b0;
    end else begin
      ld_clash <= ld_en & Wr;
    end
  end

  assign Dataout  = pipe[RD_LATENCY-1].data;
  assign addr_err = pipe[RD_LATENCY-1].err;
  assign rd_valid = pipe[RD_LATENCY-1].valid;

endmodule

// File: tb/tb_mem_responder.sv
// Drives three mem_responder instances (RD_LATENCY 1..3) with identical directed vectors;
// expected reads are queued per instance at issue time and popped by a negedge monitor.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] Address = '0;
  logic        Wr = 1'b0;
  logic [31:0] Datain = '0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [31:0] dout  [3];
  logic        vld   [3];
  logic        err   [3];
  logic        clash [3];

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    int          tag;
    logic [31:0] d;
    logic [31:0] m;
    logic        e;
  } exp_t;

  typedef struct {
    int   tag;
    logic c;
  } cexp_t;

  exp_t  q0[$];
  exp_t  q1[$];
  exp_t  q2[$];
  cexp_t cq[$];
  cexp_t cx;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.ADDR_BITS(8), .RD_LATENCY(g + 1)) u_dut (
      .clock    (clock),
      .reset    (rst_n),
      .Address  (Address),
      .Wr       (Wr),
      .Datain   (Datain),
      .Dataout  (dout[g]),
      .rd_valid (vld[g]),
      .addr_err (err[g]),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .ld_clash (clash[g])
    );
  end

  always #5 clock = ~clock;

  // Counts only edges that sample a read (reset high).
  always @(posedge clock) if (rst_n) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv,
                     input logic [31:0] msk);
    checks++;
    if (((act ^ expv) & msk) !== 32'h0) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h)", nm, act, expv, msk);
    end
  endtask

  task automatic mon_lane(input int li);
    exp_t x;
    bit   hit;
    int   want;
    hit  = 1'b0;
    want = edge_cnt - li;
    case (li)
      0: if (q0.size() > 0 && q0[0].tag == want) begin x = q0.pop_front(); hit = 1'b1; end
      1: if (q1.size() > 0 && q1[0].tag == want) begin x = q1.pop_front(); hit = 1'b1; end
      default: if (q2.size() > 0 && q2[0].tag == want) begin x = q2.pop_front(); hit = 1'b1; end
    endcase
    if (hit) begin
      if (x.m != 32'h0) chk($sformatf("L%0d data edge%0d", li + 1, want), dout[li], x.d, x.m);
      chk($sformatf("L%0d rd_valid edge%0d", li + 1, want), {31'b0, vld[li]}, 32'h1, 32'h1);
      chk($sformatf("L%0d addr_err edge%0d", li + 1, want), {31'b0, err[li]}, {31'b0, x.e}, 32'h1);
    end else begin
      chk($sformatf("L%0d idle data edge%0d", li + 1, edge_cnt), dout[li], 32'h0, 32'hFFFF_FFFF);
      chk($sformatf("L%0d idle rd_valid edge%0d", li + 1, edge_cnt), {31'b0, vld[li]}, 32'h0, 32'h1);
      chk($sformatf("L%0d idle addr_err edge%0d", li + 1, edge_cnt), {31'b0, err[li]}, 32'h0, 32'h1);
    end
  endtask

  task automatic chk_zero(input string tagname);
    for (int li = 0; li < 3; li++) begin
      chk($sformatf("%s L%0d data", tagname, li + 1), dout[li], 32'h0, 32'hFFFF_FFFF);
      chk($sformatf("%s L%0d rd_valid", tagname, li + 1), {31'b0, vld[li]}, 32'h0, 32'h1);
      chk($sformatf("%s L%0d addr_err", tagname, li + 1), {31'b0, err[li]}, 32'h0, 32'h1);
      chk($sformatf("%s L%0d ld_clash", tagname, li + 1), {31'b0, clash[li]}, 32'h0, 32'h1);
    end
  endtask

  always @(negedge clock) begin
    if (!rst_n) begin
      chk_zero("reset");
    end else begin
      for (int li = 0; li < 3; li++) mon_lane(li);
      if (cq.size() > 0 && cq[0].tag == edge_cnt) begin
        cx = cq.pop_front();
        for (int li = 0; li < 3; li++)
          chk($sformatf("L%0d ld_clash edge%0d", li + 1, edge_cnt), {31'b0, clash[li]},
              {31'b0, cx.c}, 32'h1);
      end else begin
        for (int li = 0; li < 3; li++)
          chk($sformatf("L%0d idle ld_clash edge%0d", li + 1, edge_cnt), {31'b0, clash[li]},
              32'h0, 32'h1);
      end
    end
  end

  // One clock cycle of stimulus; ed/em are the hand-computed read word and known-byte mask.
  task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [31:0] di,
                      input logic le, input logic [7:0] la, input logic [31:0] ld,
                      input logic [31:0] ed, input logic [31:0] em);
    exp_t  x;
    cexp_t c;
    @(negedge clock);
    #1;
    rst_n   = r;
    Address = a;
    Wr      = w;
    Datain  = di;
    ld_en   = le;
    ld_addr = la;
    ld_data = ld;
    if (r) begin
      x.tag = edge_cnt + 1;
      x.d   = ed;
      x.m   = em;
      x.e   = |a[31:8];
      q0.push_back(x);
      q1.push_back(x);
      q2.push_back(x);
      c.tag = edge_cnt + 1;
      c.c   = le & w;
      cq.push_back(c);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [31:0] em);
    step(1'b1, a, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, ed, em);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 8'h0, 32'h0, 32'h0, 32'h0);

    // Loader write, big-endian readback and misaligned read
    step(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 8'h10, 32'h1122_3344, 32'h0, 32'h0);
    rd(32'h10, 32'h1122_3344, 32'hFFFF_FFFF);
    rd(32'h11, 32'h2233_4400, 32'hFFFF_FF00);

    // Wrap across the top of the array
    step(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 8'hFE, 32'hAABB_CCDD, 32'h1122_3344, 32'hFFFF_FFFF);
    rd(32'h00, 32'hCCDD_0000, 32'hFFFF_0000);
    rd(32'hFE, 32'hAABB_CCDD, 32'hFFFF_FFFF);
    rd(32'hFF, 32'hBBCC_DD00, 32'hFFFF_FF00);

    // CPU write returns old data on its own edge, new data on the next
    step(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 8'h20, 32'h0, 32'h0, 32'h0);
    step(1'b1, 32'h20, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    rd(32'h20, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd(32'h21, 32'hADBE_EF00, 32'hFFFF_FF00);

    // Loader and CPU write on the same edge
    step(1'b1, 32'h40, 1'b1, 32'hFFFF_FFFF, 1'b1, 8'h40, 32'h0102_0304, 32'h0, 32'h0);
    rd(32'h40, 32'h0102_0304, 32'hFFFF_FFFF);
    rd(32'h40, 32'h0102_0304, 32'hFFFF_FFFF);

    // Upper address bits only flag addr_err
    rd(32'h0001_0020, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd(32'h20, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd(32'hFFFF_FF10, 32'h1122_3344, 32'hFFFF_FFFF);
    rd(32'h10, 32'h1122_3344, 32'hFFFF_FFFF);
    rd(32'h20, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd(32'h40, 32'h0102_0304, 32'hFFFF_FFFF);

    // Asynchronous reset mid-stream discards in-flight reads
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1 chk_zero("async reset");
    q0.delete();
    q1.delete();
    q2.delete();
    cq.delete();
    step(1'b0, 32'h10, 1'b1, 32'h1234_5678, 1'b0, 8'h0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 32'h20, 1'b0, 32'h0, 1'b1, 8'h20, 32'h5555_5555, 32'h0, 32'h0);
    step(1'b0, 32'h40, 1'b1, 32'h9999_9999, 1'b1, 8'h40, 32'h7777_7777, 32'h0, 32'h0);

    // Array retained; writes during reset were ignored
    rd(32'h10, 32'h1122_3344, 32'hFFFF_FFFF);
    rd(32'h20, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd(32'h40, 32'h0102_0304, 32'hFFFF_FFFF);
    rd(32'hFE, 32'hAABB_CCDD, 32'hFFFF_FFFF);
    rd(32'h0100_0040, 32'h0102_0304, 32'hFFFF_FFFF);
    rd(32'h40, 32'h0102_0304, 32'hFFFF_FFFF);
    rd(32'h40, 32'h0102_0304, 32'hFFFF_FFFF);
    rd(32'h40, 32'h0102_0304, 32'hFFFF_FFFF);

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
